cpu_dmem_axi_bridge: RTL and testbench

- Data-side memory responder for the MEM stage.
- Accepts the stage's single-word request (word-aligned address, read/write strobes, write data, byte enables) and performs one single-beat AXI3 read or write transaction.
- Returns the full 32-bit read word and a stall request that holds the pipeline until the transaction completes.
- Sits between the MEM stage and the soc_axi_perf interconnect, in parallel with the instruction-side bridge.

---
 rtl/cpu_dmem_axi_bridge_pkg.sv | 19 +
 rtl/cpu_axi_size_enc.sv | 28 ++
 rtl/cpu_dmem_axi_bridge.sv | 234 +++++++++++++++++++++++
 tb/tb_cpu_dmem_axi_bridge.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_dmem_axi_bridge_pkg.sv
// Shared encodings for the data-side AXI bridge: FSM states, AXI size and
// burst codes.
package cpu_dmem_axi_bridge_pkg;

  typedef enum logic [2:0] {
    BR_IDLE    = 3'd0,
    BR_RD_ADDR = 3'd1,
    BR_RD_DATA = 3'd2,
    BR_WR_REQ  = 3'd3,
    BR_WR_RESP = 3'd4,
    BR_DONE    = 3'd5
  } br_state_t;

  localparam logic [2:0] AXI_SIZE_BYTE  = 3'd0;
  localparam logic [2:0] AXI_SIZE_HALF  = 3'd1;
  localparam logic [2:0] AXI_SIZE_WORD  = 3'd2;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;

endpackage

// File: rtl/cpu_axi_size_enc.sv
// Byte-enable to AXI {size, low address offset} encoder. Single byte and
// aligned halfword masks get a narrow transfer; every other mask (including
// unaligned LWL/LWR masks and the empty mask) is issued as a full word at
// offset 0 and relies on the strobes.
module cpu_axi_size_enc
  import cpu_dmem_axi_bridge_pkg::*;
(
  input  logic [3:0] byteenable,
  output logic [2:0] size,
  output logic [1:0] offset
);

  // Decode the lane mask into transfer size and starting lane
  always_comb begin
    size   = AXI_SIZE_WORD;
    offset = 2'd0;
    case (byteenable)
      4'b0001: begin size = AXI_SIZE_BYTE; offset = 2'd0; end
      4'b0010: begin size = AXI_SIZE_BYTE; offset = 2'd1; end
      4'b0100: begin size = AXI_SIZE_BYTE; offset = 2'd2; end
      4'b1000: begin size = AXI_SIZE_BYTE; offset = 2'd3; end
      4'b0011: begin size = AXI_SIZE_HALF; offset = 2'd0; end
      4'b1100: begin size = AXI_SIZE_HALF; offset = 2'd2; end
      default: begin size = AXI_SIZE_WORD; offset = 2'd0; end
    endcase
  end

endmodule

// File: rtl/cpu_dmem_axi_bridge.sv
// MEM-stage data responder: turns one word-aligned load/store request into a
// single-beat AXI3 read or write and stalls the pipeline until it completes.
// The DONE state keeps the still-present request from being reissued while
// another stall source holds the pipeline.
module cpu_dmem_axi_bridge
  import cpu_dmem_axi_bridge_pkg::*;
#(
  parameter logic [3:0] AXI_ID = 4'd1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] mem_addr,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_byteenable,
  input  logic        pipe_hold,
  output logic [31:0] mem_rdata,
  output logic        stall_req_mem,
  output logic [31:0] araddr,
  output logic [2:0]  arsize,
  output logic        arvalid,
  output logic [3:0]  arlen,
  output logic [1:0]  arburst,
  input  logic        arready,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready,
  output logic [31:0] awaddr,
  output logic [2:0]  awsize,
  output logic        awvalid,
  output logic [3:0]  awlen,
  output logic [1:0]  awburst,
  input  logic        awready,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wlast,
  output logic        wvalid,
  input  logic        wready,
  input  logic [1:0]  bresp,
  input  logic        bvalid,
  output logic        bready,
  output logic [3:0]  arid,
  output logic [3:0]  awid,
  output logic [3:0]  wid,
  output logic [1:0]  arlock,
  output logic [3:0]  arcache,
  output logic [2:0]  arprot,
  output logic [1:0]  awlock,
  output logic [3:0]  awcache,
  output logic [2:0]  awprot,
  input  logic [3:0]  rid,
  input  logic [3:0]  bid
);

  br_state_t   state_r;
  logic [31:0] addr_r;
  logic [2:0]  size_r;
  logic [31:0] wdata_r;
  logic [3:0]  wstrb_r;
  logic        arvalid_r;
  logic        rready_r;
  logic        awvalid_r;
  logic        wvalid_r;
  logic        bready_r;
  logic        aw_done_r;
  logic        w_done_r;
  logic [31:0] mem_rdata_r;

  logic [2:0]  enc_size_s;
  logic [1:0]  enc_offset_s;
  logic [31:0] req_addr_s;
  logic        aw_done_next_s;
  logic        w_done_next_s;

  // Response codes, IDs and the always-zero address bits carry no information here
  logic        unused_s;
  assign unused_s = ^{rresp, bresp, rid, bid, mem_addr[1:0]};

  cpu_axi_size_enc u_size_enc (
    .byteenable (mem_byteenable),
    .size       (enc_size_s),
    .offset     (enc_offset_s)
  );

  assign req_addr_s = {mem_addr[31:2], enc_offset_s};

  // Per-channel completion of the write address and write data handshakes
  always_comb begin
    aw_done_next_s = aw_done_r | (awvalid_r & awready);
    w_done_next_s  = w_done_r  | (wvalid_r  & wready);
  end

  // Stall while a request is pending or in flight; release in DONE
  always_comb begin
    stall_req_mem = 1'b0;
    case (state_r)
      BR_IDLE:    stall_req_mem = mem_read | mem_write;
      BR_RD_ADDR: stall_req_mem = 1'b1;
      BR_RD_DATA: stall_req_mem = 1'b1;
      BR_WR_REQ:  stall_req_mem = 1'b1;
      BR_WR_RESP: stall_req_mem = 1'b1;
      BR_DONE:    stall_req_mem = 1'b0;
      default:    stall_req_mem = 1'b0;
    endcase
  end

  // Transaction FSM with registered channel controls and request latches
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= BR_IDLE;
      addr_r      <= 32'h0000_0000;
      size_r      <= 3'd0;
      wdata_r     <= 32'h0000_0000;
      wstrb_r     <= 4'b0000;
      arvalid_r   <= 1'b0;
      rready_r    <= 1'b0;
      awvalid_r   <= 1'b0;
      wvalid_r    <= 1'b0;
      bready_r    <= 1'b0;
      aw_done_r   <= 1'b0;
      w_done_r    <= 1'b0;
      mem_rdata_r <= 32'h0000_0000;
    end else begin
      case (state_r)
        BR_IDLE: begin
          if (mem_write) begin
            addr_r    <= req_addr_s;
            size_r    <= enc_size_s;
            wdata_r   <= mem_wdata;
            wstrb_r   <= mem_byteenable;
            awvalid_r <= 1'b1;
            wvalid_r  <= 1'b1;
            aw_done_r <= 1'b0;
            w_done_r  <= 1'b0;
            state_r   <= BR_WR_REQ;
          end else if (mem_read) begin
            addr_r    <= req_addr_s;
            size_r    <= enc_size_s;
            wdata_r   <= mem_wdata;
            wstrb_r   <= mem_byteenable;
            arvalid_r <= 1'b1;
            state_r   <= BR_RD_ADDR;
          end else begin
            state_r   <= BR_IDLE;
          end
        end
        BR_RD_ADDR: begin
          if (arready) begin
            arvalid_r <= 1'b0;
            rready_r  <= 1'b1;
            state_r   <= BR_RD_DATA;
          end
        end
        BR_RD_DATA: begin
          if (rvalid && rlast) begin
            rready_r    <= 1'b0;
            mem_rdata_r <= rdata;
            state_r     <= BR_DONE;
          end
        end
        BR_WR_REQ: begin
          if (aw_done_next_s && w_done_next_s) begin
            awvalid_r <= 1'b0;
            wvalid_r  <= 1'b0;
            aw_done_r <= 1'b0;
            w_done_r  <= 1'b0;
            bready_r  <= 1'b1;
            state_r   <= BR_WR_RESP;
          end else begin
            awvalid_r <= ~aw_done_next_s;
            wvalid_r  <= ~w_done_next_s;
            aw_done_r <= aw_done_next_s;
            w_done_r  <= w_done_next_s;
          end
        end
        BR_WR_RESP: begin
          if (bvalid) begin
            bready_r <= 1'b0;
            state_r  <= BR_DONE;
          end
        end
        BR_DONE: begin
          if (!pipe_hold) begin
            state_r <= BR_IDLE;
          end
        end
        default: begin
          arvalid_r <= 1'b0;
          rready_r  <= 1'b0;
          awvalid_r <= 1'b0;
          wvalid_r  <= 1'b0;
          bready_r  <= 1'b0;
          aw_done_r <= 1'b0;
          w_done_r  <= 1'b0;
          state_r   <= BR_IDLE;
        end
      endcase
    end
  end

  assign mem_rdata = mem_rdata_r;

  assign araddr  = addr_r;
  assign arsize  = size_r;
  assign arlen   = 4'd0;
  assign arburst = AXI_BURST_INCR;
  assign arvalid = arvalid_r;
  assign arid    = AXI_ID;
  assign arlock  = 2'b00;
  assign arcache = 4'b0000;
  assign arprot  = 3'b000;
  assign rready  = rready_r;

  assign awaddr  = addr_r;
  assign awsize  = size_r;
  assign awlen   = 4'd0;
  assign awburst = AXI_BURST_INCR;
  assign awvalid = awvalid_r;
  assign awid    = AXI_ID;
  assign awlock  = 2'b00;
  assign awcache = 4'b0000;
  assign awprot  = 3'b000;

  assign wdata   = wdata_r;
  assign wstrb   = wstrb_r;
  assign wlast   = 1'b1;
  assign wvalid  = wvalid_r;
  assign wid     = AXI_ID;
  assign bready  = bready_r;

endmodule

// File: tb/tb_cpu_dmem_axi_bridge.sv
// Directed bench for cpu_dmem_axi_bridge with a small AXI slave whose
// per-channel ready/valid delays are set per test.
module tb_cpu_dmem_axi_bridge;

  logic        clk;
  logic        rst;
  logic [31:0] mem_addr;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_byteenable;
  logic        pipe_hold;
  logic [31:0] mem_rdata;
  logic        stall_req_mem;
  logic [31:0] araddr;
  logic [2:0]  arsize;
  logic        arvalid;
  logic [3:0]  arlen;
  logic [1:0]  arburst;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;
  logic [31:0] awaddr;
  logic [2:0]  awsize;
  logic        awvalid;
  logic [3:0]  awlen;
  logic [1:0]  awburst;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [3:0]  arid;
  logic [3:0]  awid;
  logic [3:0]  wid;
  logic [1:0]  arlock;
  logic [3:0]  arcache;
  logic [2:0]  arprot;
  logic [1:0]  awlock;
  logic [3:0]  awcache;
  logic [2:0]  awprot;
  logic [3:0]  rid;
  logic [3:0]  bid;

  cpu_dmem_axi_bridge dut (
    .clk(clk), .rst(rst),
    .mem_addr(mem_addr), .mem_read(mem_read), .mem_write(mem_write),
    .mem_wdata(mem_wdata), .mem_byteenable(mem_byteenable), .pipe_hold(pipe_hold),
    .mem_rdata(mem_rdata), .stall_req_mem(stall_req_mem),
    .araddr(araddr), .arsize(arsize), .arvalid(arvalid), .arlen(arlen), .arburst(arburst),
    .arready(arready),
    .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awaddr(awaddr), .awsize(awsize), .awvalid(awvalid), .awlen(awlen), .awburst(awburst),
    .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .arid(arid), .awid(awid), .wid(wid),
    .arlock(arlock), .arcache(arcache), .arprot(arprot),
    .awlock(awlock), .awcache(awcache), .awprot(awprot),
    .rid(rid), .bid(bid)
  );

  int n_vec = 0;
  int n_err = 0;

  // slave configuration (written by the main sequence)
  int          ar_wait = 0, r_wait = 0, aw_wait = 0, w_wait = 0, b_wait = 0;
  logic [31:0] slv_rdata = 32'h0;

  // slave state and observations (written by the slave only)
  int          ar_cnt, r_cnt, aw_cnt, w_cnt, b_cnt;
  logic        r_pend, b_pend, aw_got, w_got;
  logic        hs_ar, hs_r, hs_aw, hs_w, hs_b;
  int          ar_beats = 0, r_beats = 0, aw_beats = 0, w_beats = 0, b_beats = 0;
  int          awv_cycles = 0, wv_cycles = 0;
  logic [31:0] seen_araddr, seen_awaddr, seen_wdata;
  logic [2:0]  seen_arsize, seen_awsize;
  logic [3:0]  seen_arlen, seen_awlen, seen_wstrb, seen_arid, seen_awid, seen_wid;
  logic [1:0]  seen_arburst, seen_awburst;
  logic        seen_wlast;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // AXI slave: acts on negedges, handshakes complete on the following posedge
  initial begin
    arready = 1'b0; rvalid = 1'b0; rlast = 1'b0; rdata = 32'h0; rresp = 2'b10;
    awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b10; rid = 4'hF; bid = 4'hF;
    ar_cnt = 0; r_cnt = 0; aw_cnt = 0; w_cnt = 0; b_cnt = 0;
    r_pend = 1'b0; b_pend = 1'b0; aw_got = 1'b0; w_got = 1'b0;
    hs_ar = 1'b0; hs_r = 1'b0; hs_aw = 1'b0; hs_w = 1'b0; hs_b = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        arready = 1'b0; rvalid = 1'b0; rlast = 1'b0;
        awready = 1'b0; wready = 1'b0; bvalid = 1'b0;
        ar_cnt = 0; r_cnt = 0; aw_cnt = 0; w_cnt = 0; b_cnt = 0;
        r_pend = 1'b0; b_pend = 1'b0; aw_got = 1'b0; w_got = 1'b0;
        hs_ar = 1'b0; hs_r = 1'b0; hs_aw = 1'b0; hs_w = 1'b0; hs_b = 1'b0;
      end else begin
        if (hs_ar) begin arready = 1'b0; ar_beats++; r_pend = 1'b1; r_cnt = 0; end
        if (hs_r)  begin rvalid = 1'b0; rlast = 1'b0; r_beats++; end
        if (hs_aw) begin awready = 1'b0; aw_beats++; aw_got = 1'b1; end
        if (hs_w)  begin wready = 1'b0; w_beats++; w_got = 1'b1; end
        if (hs_b)  begin bvalid = 1'b0; b_beats++; end
        if (aw_got && w_got) begin aw_got = 1'b0; w_got = 1'b0; b_pend = 1'b1; b_cnt = 0; end

        if (arvalid && !arready) begin
          if (ar_cnt >= ar_wait) begin arready = 1'b1; ar_cnt = 0; end else ar_cnt++;
        end
        if (r_pend) begin
          if (r_cnt >= r_wait) begin rvalid = 1'b1; rlast = 1'b1; rdata = slv_rdata; r_pend = 1'b0; end
          else r_cnt++;
        end
        if (awvalid && !awready) begin
          if (aw_cnt >= aw_wait) begin awready = 1'b1; aw_cnt = 0; end else aw_cnt++;
        end
        if (wvalid && !wready) begin
          if (w_cnt >= w_wait) begin wready = 1'b1; w_cnt = 0; end else w_cnt++;
        end
        if (b_pend) begin
          if (b_cnt >= b_wait) begin bvalid = 1'b1; b_pend = 1'b0; end else b_cnt++;
        end

        if (awvalid) awv_cycles++;
        if (wvalid)  wv_cycles++;

        hs_ar = arvalid && arready;
        hs_r  = rvalid && rready;
        hs_aw = awvalid && awready;
        hs_w  = wvalid && wready;
        hs_b  = bvalid && bready;
        if (hs_ar) begin
          seen_araddr = araddr; seen_arsize = arsize; seen_arlen = arlen;
          seen_arburst = arburst; seen_arid = arid;
        end
        if (hs_aw) begin
          seen_awaddr = awaddr; seen_awsize = awsize; seen_awlen = awlen;
          seen_awburst = awburst; seen_awid = awid;
        end
        if (hs_w) begin
          seen_wdata = wdata; seen_wstrb = wstrb; seen_wlast = wlast; seen_wid = wid;
        end
      end
    end
  end

  // Present a request in the current (IDLE) cycle and count stalled cycles
  task automatic run_req(input logic rd, input logic wr, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [3:0] be, output int stalls);
    mem_read = rd; mem_write = wr; mem_addr = addr; mem_wdata = wd; mem_byteenable = be;
    #1;
    stalls = 0;
    for (int i = 0; i < 40; i++) begin
      if (!stall_req_mem) break;
      stalls++;
      @(negedge clk); #1;
    end
  endtask

  // Withdraw the request and move to the next cycle
  task automatic end_req();
    mem_read = 1'b0; mem_write = 1'b0;
    @(negedge clk); #1;
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] exp_addr;
    logic [2:0]  exp_size;
  } mask_vec_t;

  mask_vec_t mvec[5] = '{
    '{32'h2000_0008, 4'b0011, 32'h2000_0008, 3'd1},
    '{32'h2000_0008, 4'b1100, 32'h2000_000A, 3'd1},
    '{32'h1000_0000, 4'b0111, 32'h1000_0000, 3'd2},
    '{32'h3000_000C, 4'b1000, 32'h3000_000F, 3'd0},
    '{32'h3000_000C, 4'b1110, 32'h3000_000C, 3'd2}
  };

  initial begin
    int st;
    int ar0, aw0, w0, b0, awv0, wv0;
    rst = 1'b1; mem_addr = 32'h0; mem_read = 1'b0; mem_write = 1'b0;
    mem_wdata = 32'h0; mem_byteenable = 4'h0; pipe_hold = 1'b0;

    // reset state
    repeat (3) @(negedge clk);
    #1;
    chk("rst_arvalid", 32'(arvalid), 32'd0);
    chk("rst_rready", 32'(rready), 32'd0);
    chk("rst_awvalid", 32'(awvalid), 32'd0);
    chk("rst_wvalid", 32'(wvalid), 32'd0);
    chk("rst_bready", 32'(bready), 32'd0);
    chk("rst_rdata", mem_rdata, 32'h0);
    chk("rst_stall", 32'(stall_req_mem), 32'd0);
    chk("rst_araddr", araddr, 32'h0);
    chk("rst_wstrb", 32'(wstrb), 32'd0);
    chk("tie_wlast", 32'(wlast), 32'd1);
    chk("tie_cache_prot", 32'({arlock, arcache, arprot, awlock, awcache, awprot}), 32'd0);
    rst = 1'b0;
    @(negedge clk); #1;

    // zero-wait read
    slv_rdata = 32'hDEAD_BEEF;
    ar0 = ar_beats;
    run_req(1'b1, 1'b0, 32'h1FC0_0010, 32'h0, 4'b1111, st);
    chk("rd_stalls", 32'(st), 32'd3);
    chk("rd_data", mem_rdata, 32'hDEAD_BEEF);
    chk("rd_stall_done", 32'(stall_req_mem), 32'd0);
    chk("rd_araddr", seen_araddr, 32'h1FC0_0010);
    chk("rd_arsize", 32'(seen_arsize), 32'd2);
    chk("rd_arlen", 32'(seen_arlen), 32'd0);
    chk("rd_arburst", 32'(seen_arburst), 32'd1);
    chk("rd_arid", 32'(seen_arid), 32'd1);
    chk("rd_beats", 32'(ar_beats - ar0), 32'd1);
    end_req();

    // pipe_hold keeps the bridge in DONE
    slv_rdata = 32'hCAFE_F00D;
    run_req(1'b1, 1'b0, 32'h0000_1000, 32'h0, 4'b1111, st);
    chk("hold_rd_stalls", 32'(st), 32'd3);
    pipe_hold = 1'b1;
    ar0 = ar_beats;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #1;
      chk("hold_stall", 32'(stall_req_mem), 32'd0);
      chk("hold_rdata", mem_rdata, 32'hCAFE_F00D);
      chk("hold_arvalid", 32'(arvalid), 32'd0);
    end
    chk("hold_no_reissue", 32'(ar_beats - ar0), 32'd0);
    pipe_hold = 1'b0;
    slv_rdata = 32'h0BAD_C0DE;
    @(negedge clk); #1;
    chk("hold_release_idle", 32'(stall_req_mem), 32'd1);
    run_req(1'b1, 1'b0, 32'h0000_1000, 32'h0, 4'b1111, st);
    chk("hold_next_stalls", 32'(st), 32'd3);
    chk("hold_next_rdata", mem_rdata, 32'h0BAD_C0DE);
    chk("hold_next_beats", 32'(ar_beats - ar0), 32'd1);
    end_req();

    // SB write, zero-wait
    aw0 = aw_beats; w0 = w_beats; b0 = b_beats;
    run_req(1'b0, 1'b1, 32'h8000_0004, 32'h00AB_0000, 4'b0100, st);
    chk("sb_stalls", 32'(st), 32'd3);
    chk("sb_awaddr", seen_awaddr, 32'h8000_0006);
    chk("sb_awsize", 32'(seen_awsize), 32'd0);
    chk("sb_wstrb", 32'(seen_wstrb), 32'b0100);
    chk("sb_wdata", seen_wdata, 32'h00AB_0000);
    chk("sb_wlast", 32'(seen_wlast), 32'd1);
    chk("sb_ids", 32'({seen_awid, seen_wid}), 32'h11);
    chk("sb_awlen_burst", 32'({seen_awlen, seen_awburst}), 32'b0000_01);
    chk("sb_beats", 32'({aw_beats - aw0, w_beats - w0, b_beats - b0}), {32'd1, 32'd1, 32'd1});
    end_req();

    // W accepted three cycles before AW
    aw_wait = 3;
    aw0 = aw_beats; w0 = w_beats; b0 = b_beats; awv0 = awv_cycles; wv0 = wv_cycles;
    run_req(1'b0, 1'b1, 32'h8000_0010, 32'h1122_3344, 4'b1111, st);
    chk("ord_stalls", 32'(st), 32'd6);
    chk("ord_wvalid_cycles", 32'(wv_cycles - wv0), 32'd1);
    chk("ord_awvalid_cycles", 32'(awv_cycles - awv0), 32'd4);
    chk("ord_aw_beats", 32'(aw_beats - aw0), 32'd1);
    chk("ord_w_beats", 32'(w_beats - w0), 32'd1);
    chk("ord_b_beats", 32'(b_beats - b0), 32'd1);
    chk("ord_awaddr", seen_awaddr, 32'h8000_0010);
    chk("ord_awsize", 32'(seen_awsize), 32'd2);
    chk("ord_wdata", seen_wdata, 32'h1122_3344);
    aw_wait = 0;
    end_req();

    // partial-word masks on reads
    for (int k = 0; k < 5; k++) begin
      slv_rdata = 32'h5A5A_0000 + 32'(k);
      run_req(1'b1, 1'b0, mvec[k].addr, 32'h0, mvec[k].be, st);
      chk($sformatf("mask%0d_addr", k), seen_araddr, mvec[k].exp_addr);
      chk($sformatf("mask%0d_size", k), 32'(seen_arsize), 32'(mvec[k].exp_size));
      chk($sformatf("mask%0d_rdata", k), mem_rdata, 32'h5A5A_0000 + 32'(k));
      end_req();
    end

    // empty mask write goes out as a full word with no strobes
    run_req(1'b0, 1'b1, 32'h4000_0004, 32'hFFFF_FFFF, 4'b0000, st);
    chk("be0_awaddr", seen_awaddr, 32'h4000_0004);
    chk("be0_awsize", 32'(seen_awsize), 32'd2);
    chk("be0_wstrb", 32'(seen_wstrb), 32'd0);
    end_req();

    // write has priority when both strobes are set
    ar0 = ar_beats; aw0 = aw_beats;
    run_req(1'b1, 1'b1, 32'h4000_0020, 32'h0102_0304, 4'b1111, st);
    chk("prio_aw", 32'(aw_beats - aw0), 32'd1);
    chk("prio_ar", 32'(ar_beats - ar0), 32'd0);
    chk("prio_wdata", seen_wdata, 32'h0102_0304);
    end_req();

    // reset while waiting in RD_DATA
    r_wait = 5;
    mem_read = 1'b1; mem_addr = 32'h0000_0080; mem_byteenable = 4'b1111;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); #1;
      if (rready) break;
    end
    chk("rst_mid_in_rd_data", 32'(rready), 32'd1);
    rst = 1'b1; mem_read = 1'b0;
    #1;
    chk("rst_mid_valids", 32'({arvalid, rready, awvalid, wvalid, bready}), 32'd0);
    chk("rst_mid_rdata", mem_rdata, 32'h0);
    chk("rst_mid_stall", 32'(stall_req_mem), 32'd0);
    @(negedge clk); #1;
    rst = 1'b0; r_wait = 0;
    @(negedge clk); #1;
    slv_rdata = 32'h1357_9BDF;
    ar0 = ar_beats;
    run_req(1'b1, 1'b0, 32'h0000_0040, 32'h0, 4'b1111, st);
    chk("post_rst_stalls", 32'(st), 32'd3);
    chk("post_rst_rdata", mem_rdata, 32'h1357_9BDF);
    chk("post_rst_araddr", seen_araddr, 32'h0000_0040);
    chk("post_rst_beats", 32'(ar_beats - ar0), 32'd1);
    end_req();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
